// File: rtl/writeback_arbiter_if.sv
// Writeback bundle between the ALU/memory producers, the decode read indices
// and the arbiter. The register file write port and bypass results are returned here.
interface writeback_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          alu_valid;
  logic [7:0]    alu_dest;
  logic [31:0]   alu_data;
  logic          alu_hold;

  logic          mem_valid;
  logic [7:0]    mem_dest;
  logic [31:0]   mem_data;
  logic          mem_ready;

  logic [7:0]    dest;
  logic [31:0]   write_data;
  logic          write_enable;

  logic [7:0]    src1;
  logic [7:0]    src2;
  logic          bypass1_hit;
  logic [31:0]   bypass1_data;
  logic          bypass2_hit;
  logic [31:0]   bypass2_data;

  logic [CW-1:0] pending_count;

  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, src1, src2,
    input  alu_hold, mem_ready, dest, write_data, write_enable,
           bypass1_hit, bypass1_data, bypass2_hit, bypass2_data, pending_count
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, src1, src2,
    output alu_hold, mem_ready, dest, write_data, write_enable,
           bypass1_hit, bypass1_data, bypass2_hit, bypass2_data, pending_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU results (highest priority) and buffered memory/FPU results onto the
// register file's single write port, and forwards the registered write to decode.
module writeback_arbiter #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ZERO_REG   = 8'd255
) (
  input  logic                clock,
  input  logic                reset_n,
  writeback_arbiter_if.slave  wb
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [7:0]    fifo_dest [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic alu_write;
  logic mem_accept;
  logic fifo_nonempty;
  logic dequeue;
  logic direct;
  logic enqueue;

  // Ready and hold depend only on the registered count so the producer sees no
  // combinational path from its own valid.
  assign wb.mem_ready     = reset_n && (count < DEPTH_C);
  assign wb.alu_hold      = (count == DEPTH_C);
  assign wb.pending_count = count;

  always_comb begin
    alu_write     = wb.alu_valid && (wb.alu_dest != ZERO_REG);
    mem_accept    = wb.mem_valid && wb.mem_ready;
    fifo_nonempty = (count != '0);
    dequeue       = !alu_write && fifo_nonempty;
    direct        = !alu_write && !fifo_nonempty && mem_accept && (wb.mem_dest != ZERO_REG);
    enqueue       = mem_accept && (wb.mem_dest != ZERO_REG) && !direct;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb.write_enable <= 1'b0;
      wb.dest         <= '0;
      wb.write_data   <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
    end else begin
      wb.write_enable <= alu_write || dequeue || direct;
      if (alu_write) begin
        wb.dest       <= wb.alu_dest;
        wb.write_data <= wb.alu_data;
      end else if (dequeue) begin
        wb.dest       <= fifo_dest[rd_ptr];
        wb.write_data <= fifo_data[rd_ptr];
      end else if (direct) begin
        wb.dest       <= wb.mem_dest;
        wb.write_data <= wb.mem_data;
      end
      if (dequeue) rd_ptr <= rd_ptr + 1'b1;
      if (enqueue) wr_ptr <= wr_ptr + 1'b1;
      if (enqueue && !dequeue)      count <= count + 1'b1;
      else if (dequeue && !enqueue) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (enqueue) begin
      fifo_dest[wr_ptr] <= wb.mem_dest;
      fifo_data[wr_ptr] <= wb.mem_data;
    end
  end

  always_comb begin
    wb.bypass1_hit  = wb.write_enable && (wb.src1 == wb.dest) && (wb.src1 != ZERO_REG);
    wb.bypass2_hit  = wb.write_enable && (wb.src2 == wb.dest) && (wb.src2 != ZERO_REG);
    wb.bypass1_data = wb.bypass1_hit ? wb.write_data : 32'd0;
    wb.bypass2_data = wb.bypass2_hit ? wb.write_data : 32'd0;
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: inputs change and outputs are checked
// on the falling edge, so every check sees settled registered state.
module tb_writeback_arbiter;
  logic clock;
  logic reset_n;
  int   compared;
  int   mismatched;

  writeback_arbiter_if #(.FIFO_DEPTH(4)) wb ();

  writeback_arbiter #(.FIFO_DEPTH(4), .ZERO_REG(8'd255)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .wb      (wb.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic av, input logic [7:0] ad, input logic [31:0] adata,
                               input logic mv, input logic [7:0] md, input logic [31:0] mdata);
    wb.alu_valid = av;
    wb.alu_dest  = ad;
    wb.alu_data  = adata;
    wb.mem_valid = mv;
    wb.mem_dest  = md;
    wb.mem_data  = mdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    wb.src1    = 8'd0;
    wb.src2    = 8'd0;
    @(negedge clock);

    // Reset with a memory result offered
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, 8'd20, 32'h20);
    checkOutput("rst_mem_ready", 32'(wb.mem_ready), 32'd0);
    tick();
    tick();
    checkOutput("rst_we", 32'(wb.write_enable), 32'd0);
    checkOutput("rst_dest", 32'(wb.dest), 32'd0);
    checkOutput("rst_wdata", wb.write_data, 32'd0);
    checkOutput("rst_count", 32'(wb.pending_count), 32'd0);
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0);
    checkOutput("post_rst_ready", 32'(wb.mem_ready), 32'd1);
    checkOutput("post_rst_hold", 32'(wb.alu_hold), 32'd0);

    // ALU only, then bypass of the registered write
    applyStimulus(1'b1, 8'd5, 32'hDEADBEEF, 1'b0, 8'd0, 32'd0);
    tick();
    wb.src1 = 8'd5;
    wb.src2 = 8'd6;
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0);
    checkOutput("alu_dest", 32'(wb.dest), 32'd5);
    checkOutput("alu_wdata", wb.write_data, 32'hDEADBEEF);
    checkOutput("alu_we", 32'(wb.write_enable), 32'd1);
    checkOutput("byp1_hit", 32'(wb.bypass1_hit), 32'd1);
    checkOutput("byp1_data", wb.bypass1_data, 32'hDEADBEEF);
    checkOutput("byp2_hit", 32'(wb.bypass2_hit), 32'd0);
    checkOutput("byp2_data", wb.bypass2_data, 32'd0);
    tick();
    checkOutput("idle_we", 32'(wb.write_enable), 32'd0);
    checkOutput("idle_dest_hold", 32'(wb.dest), 32'd5);
    checkOutput("idle_byp1_hit", 32'(wb.bypass1_hit), 32'd0);

    // ALU and memory collide; memory waits one cycle in the FIFO
    applyStimulus(1'b1, 8'd3, 32'h33, 1'b1, 8'd7, 32'h11);
    tick();
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0);
    checkOutput("coll_alu_dest", 32'(wb.dest), 32'd3);
    checkOutput("coll_alu_data", wb.write_data, 32'h33);
    checkOutput("coll_count1", 32'(wb.pending_count), 32'd1);
    tick();
    checkOutput("coll_mem_dest", 32'(wb.dest), 32'd7);
    checkOutput("coll_mem_data", wb.write_data, 32'h11);
    checkOutput("coll_mem_we", 32'(wb.write_enable), 32'd1);
    checkOutput("coll_count0", 32'(wb.pending_count), 32'd0);
    tick();
    checkOutput("coll_idle_we", 32'(wb.write_enable), 32'd0);

    // ALU busy for 6 cycles while memory offers dests 10..14; only four fit
    for (int c = 0; c < 6; c++) begin
      int k;
      k = (c < 4) ? c : 4;
      applyStimulus(1'b1, 8'(20 + c), 32'(c), 1'b1, 8'(10 + k), 32'h100 + 32'(k));
      if (c < 4) begin
        checkOutput($sformatf("fill_ready_%0d", c), 32'(wb.mem_ready), 32'd1);
        checkOutput($sformatf("fill_count_%0d", c), 32'(wb.pending_count), 32'(c));
      end else begin
        checkOutput($sformatf("full_ready_%0d", c), 32'(wb.mem_ready), 32'd0);
        checkOutput($sformatf("full_hold_%0d", c), 32'(wb.alu_hold), 32'd1);
        checkOutput($sformatf("full_count_%0d", c), 32'(wb.pending_count), 32'd4);
      end
      tick();
      checkOutput($sformatf("fill_alu_dest_%0d", c), 32'(wb.dest), 32'(20 + c));
      checkOutput($sformatf("fill_alu_we_%0d", c), 32'(wb.write_enable), 32'd1);
    end

    // Full FIFO draining while memory still offers 14: not accepted this cycle
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, 8'd14, 32'h104);
    checkOutput("full_deq_ready", 32'(wb.mem_ready), 32'd0);
    tick();
    checkOutput("drain_dest10", 32'(wb.dest), 32'd10);
    checkOutput("drain_data10", wb.write_data, 32'h100);
    checkOutput("drain_count3", 32'(wb.pending_count), 32'd3);
    checkOutput("drain_ready", 32'(wb.mem_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0);
    checkOutput("drain_dest11", 32'(wb.dest), 32'd11);
    checkOutput("drain_count_same", 32'(wb.pending_count), 32'd3);
    tick();
    checkOutput("drain_dest12", 32'(wb.dest), 32'd12);
    checkOutput("drain_count2", 32'(wb.pending_count), 32'd2);
    tick();
    checkOutput("drain_dest13", 32'(wb.dest), 32'd13);
    checkOutput("drain_data13", wb.write_data, 32'h103);
    tick();
    checkOutput("drain_dest14", 32'(wb.dest), 32'd14);
    checkOutput("drain_data14", wb.write_data, 32'h104);
    checkOutput("drain_count0", 32'(wb.pending_count), 32'd0);
    tick();
    checkOutput("drain_idle_we", 32'(wb.write_enable), 32'd0);

    // ALU to zero register lets memory pass straight through
    applyStimulus(1'b1, 8'd255, 32'h77, 1'b1, 8'd9, 32'h42);
    tick();
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b1, 8'd255, 32'h55);
    checkOutput("zr_dest", 32'(wb.dest), 32'd9);
    checkOutput("zr_wdata", wb.write_data, 32'h42);
    checkOutput("zr_we", 32'(wb.write_enable), 32'd1);
    checkOutput("zr_count", 32'(wb.pending_count), 32'd0);
    checkOutput("zr_mem_ready", 32'(wb.mem_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0);
    checkOutput("memzr_we", 32'(wb.write_enable), 32'd0);
    checkOutput("memzr_count", 32'(wb.pending_count), 32'd0);

    // Queue three results behind the ALU, then reset discards them
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 8'd30, 32'h30, 1'b1, 8'(40 + c), 32'h400 + 32'(c));
      tick();
    end
    applyStimulus(1'b0, 8'd0, 32'd0, 1'b0, 8'd0, 32'd0);
    checkOutput("q3_count", 32'(wb.pending_count), 32'd3);
    reset_n = 1'b0;
    #1;
    checkOutput("q3_rst_ready", 32'(wb.mem_ready), 32'd0);
    tick();
    checkOutput("q3_rst_count", 32'(wb.pending_count), 32'd0);
    checkOutput("q3_rst_we", 32'(wb.write_enable), 32'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("q3_post_we", 32'(wb.write_enable), 32'd0);
    tick();
    checkOutput("q3_post_we2", 32'(wb.write_enable), 32'd0);
    checkOutput("q3_post_count", 32'(wb.pending_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the 256-entry register file. Entry 255 is hardwired zero.
- Merges two result sources onto the file's single write port (dest / write_data / write_enable):
  - the single-cycle ALU, which always has priority and cannot be back-pressured;
  - the long-latency memory/FPU path, which uses valid/ready and is buffered in a small FIFO.
- Supplies bypass data for the write sitting in its output register, because that value is not yet visible through the register file's combinational read ports.

Parameters:
- FIFO_DEPTH, 4: memory-result buffer entries; power of two, at least 2.
- ZERO_REG, 8'd255: register index that is never written.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_dest  in  8  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid  in  1  memory-path result offered.
- mem_dest  in  8  memory-path destination register.
- mem_data  in  32  memory-path result.
- mem_ready  out  1  memory-path result accepted when mem_valid and mem_ready are both high.
- alu_hold  out  1  front end must not issue an ALU op that writes a register next cycle.
- dest  out  8  register file write address (registered).
- write_data  out  32  register file write data (registered).
- write_enable  out  1  register file write strobe (registered).
- src1  in  8  decode read index 1.
- src2  in  8  decode read index 2.
- bypass1_hit  out  1  src1 matches the pending write.
- bypass1_data  out  32  forwarded data for src1.
- bypass2_hit  out  1  src2 matches the pending write.
- bypass2_data  out  32  forwarded data for src2.
- pending_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (reset_n low at a posedge):
  - write_enable=0, dest=0, write_data=0;
  - FIFO emptied, pending_count=0, alu_hold=0;
  - mem_ready is forced 0 while reset_n is low.
- Effective ALU write: alu_valid && alu_dest!=ZERO_REG.
  - An ALU result addressed to ZERO_REG is discarded and does not occupy the port.
- mem_ready = reset_n && (pending_count < FIFO_DEPTH). Combinational from the registered count only; never from mem_valid.
- Port selection each cycle, in priority order, loaded into dest/write_data at the posedge:
  1. effective ALU write;
  2. otherwise FIFO head (dequeued);
  3. otherwise accepted mem input with mem_dest!=ZERO_REG, passed straight through (not enqueued);
  4. otherwise write_enable=0; dest and write_data hold their previous values.
- Latency: one cycle from input to write_enable. A FIFO entry needs at least one cycle without an effective ALU write to drain.
- Enqueue: an accepted mem result is enqueued unless it took the direct path (step 3).
  - Accepted results with mem_dest==ZERO_REG are dropped and never enqueued.
- Enqueue and dequeue in the same cycle are legal:
  - count is unchanged;
  - a full FIFO still reports mem_ready=0 that cycle (no enqueue-on-full even with a simultaneous dequeue).
- FIFO is circular: read/write pointers wrap modulo FIFO_DEPTH; occupancy is tracked by a separate counter.
- FIFO order is strict: memory results reach the port in acceptance order.
- alu_hold = (pending_count == FIFO_DEPTH), registered-count based.
  - Front end issues a bubble so the head can drain.
  - If an effective ALU write still arrives while alu_hold=1, the ALU wins and the FIFO waits; no data is lost.
- Bypass:
  - bypassN_hit = write_enable && srcN==dest && srcN!=ZERO_REG;
  - bypassN_data = write_data when hit, else 0;
  - purely combinational from the registered outputs.
- WAW ordering between the ALU and memory paths is out of scope. The upstream scoreboard guarantees at most one in-flight write per register.
- Reset mid-operation discards all queued results; the memory-path producer must re-issue them.

Test Plan:
- Reset with mem_valid=1 -> mem_ready=0 during reset; after release write_enable=0, pending_count=0, mem_ready=1.
- ALU only, alu_dest=5, alu_data=32'hDEADBEEF -> next cycle dest=5, write_data=32'hDEADBEEF, write_enable=1. Same cycle src1=5 -> bypass1_hit=1, bypass1_data=32'hDEADBEEF.
- ALU (dest 3) and mem (dest 7, 32'h11) in the same cycle -> ALU written at cycle +1 with pending_count=1; mem written at cycle +2 once alu_valid=0; pending_count back to 0.
- alu_valid held high for 6 cycles while mem offers results with dests 10,11,12,13,14 -> four accepted, mem_ready=0 and alu_hold=1 at count 4. Drain order 10,11,12,13, then 14 is accepted; no loss or reorder; pointers wrap.
- alu_dest=255 with mem_valid (dest 9, 32'h42) in the same cycle -> mem passes directly: dest=9, write_data=32'h42, write_enable=1 next cycle, pending_count=0. mem_dest=255 alone -> accepted, write_enable=0.
- FIFO full with a simultaneous dequeue (alu_valid=0) -> count goes 4 to 3 and mem_ready=0 that cycle. Assert reset_n=0 with 3 queued -> all dropped, no write after release.
